alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: accepts one command at a time, either performs a
// register move directly or drives an external multi-cycle ALU for LATENCY
// cycles and captures its result into the accumulator.
//
// Handshake: a command transfers on a rising edge where cmd_valid=1 and
// cmd_ready=1. cmd_ready is high only in IDLE and never while rst is high.
// The command fields are latched on that edge, so later input changes are
// ignored. Completion is signalled by a one-cycle done pulse, with err
// qualifying it for illegal commands.
module alu_op_sequencer #(
  parameter int WIDTH   = 24,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [1:0]       cmd_src,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [3:0]       alu_operation,
  output logic             alu_enable,
  output logic [WIDTH-1:0] a_bus,
  output logic [WIDTH-1:0] b_bus,
  input  logic [WIDTH-1:0] c_bus,
  input  logic             z_flag,
  output logic [WIDTH-1:0] ac,
  output logic             zero,
  output logic             done,
  output logic             err,
  output logic [2:0]       fsm_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [3:0] OP_MOVE = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0010;

  state_t           state, next_state;
  logic [3:0]       cnt;
  logic [3:0]       op_q;
  logic [1:0]       src_q;
  logic [WIDTH-1:0] imm_q;
  logic             illegal_q;
  logic [WIDTH-1:0] r1, r2;

  logic accept;
  logic cmd_is_alu;
  logic cmd_is_illegal;

  assign cmd_ready      = (state == IDLE) && !rst;
  assign accept         = cmd_valid && cmd_ready;
  assign cmd_is_alu     = (cmd_op != OP_MOVE) && (cmd_op < 4'd12);
  assign cmd_is_illegal = (cmd_op >= 4'd12) || ((cmd_op == OP_MOVE) && (cmd_src == 2'b11));
  assign a_bus          = ac;
  assign fsm_state      = state;

  // B operand follows the most recently latched source select in every state.
  always_comb begin
    b_bus = '0;
    case (src_q)
      2'b00:   b_bus = r1;
      2'b01:   b_bus = r2;
      2'b10:   b_bus = imm_q;
      default: b_bus = '0;
    endcase
  end

  // Next-state logic; moves and illegal commands skip straight to DONE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_is_alu) next_state = ISSUE;
          else            next_state = DONE;
        end
      end
      ISSUE:   next_state = WAIT;
      WAIT:    if (cnt == 4'd1) next_state = CAPTURE;
      CAPTURE: next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, command latch, registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      op_q          <= '0;
      src_q         <= '0;
      imm_q         <= '0;
      illegal_q     <= 1'b0;
      ac            <= '0;
      r1            <= '0;
      r2            <= '0;
      zero          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      alu_enable    <= 1'b0;
      alu_operation <= '0;
    end else begin
      state <= next_state;
      // done/err are registered from DONE, so the pulse appears in the
      // following (IDLE) cycle and err can never be high without done.
      done  <= (state == DONE);
      err   <= (state == DONE) && illegal_q;
      // Enable is high exactly while in ISSUE and WAIT, giving one rising
      // edge per ALU operation.
      alu_enable <= (next_state == ISSUE) || (next_state == WAIT);

      if (accept) begin
        op_q      <= cmd_op;
        src_q     <= cmd_src;
        imm_q     <= cmd_imm;
        illegal_q <= cmd_is_illegal;
        if (cmd_is_alu) alu_operation <= cmd_op;
        if (cmd_op == OP_MOVE) begin
          case (cmd_src)
            2'b00: r1 <= ac;
            2'b01: r2 <= ac;
            2'b10: begin
              ac   <= cmd_imm;
              zero <= (cmd_imm == '0);
            end
            default: ;
          endcase
        end
      end

      case (state)
        ISSUE: cnt <= 4'(LATENCY);
        WAIT:  cnt <= cnt - 4'd1;
        CAPTURE: begin
          ac   <= c_bus;
          zero <= (op_q == OP_SUB) ? z_flag : (c_bus == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU and a
// scoreboard of expected {err, zero, ac} results.
module tb_alu_op_sequencer;

  localparam int W = 24;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_op;
  logic [1:0]   cmd_src;
  logic [W-1:0] cmd_imm;
  logic [3:0]   alu_operation;
  logic         alu_enable;
  logic [W-1:0] a_bus, b_bus, c_bus;
  logic         z_flag;
  logic [W-1:0] ac;
  logic         zero, done, err;
  logic [2:0]   fsm_state;

  // ALU environment controls
  logic         z_invert = 1'b0;
  logic         c_force  = 1'b0;
  logic [W-1:0] c_force_val = '0;

  int checks = 0;
  int errors = 0;

  // reference state
  logic [W-1:0] m_ac = '0, m_r1 = '0, m_r2 = '0;
  logic         m_zero = 1'b0;
  logic [W+1:0] exp_q[$];

  alu_op_sequencer #(.WIDTH(W), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
    .alu_operation(alu_operation), .alu_enable(alu_enable),
    .a_bus(a_bus), .b_bus(b_bus), .c_bus(c_bus), .z_flag(z_flag),
    .ac(ac), .zero(zero), .done(done), .err(err), .fsm_state(fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a + 1'b1;
      default: return a ^ b;
    endcase
  endfunction

  // behavioural ALU
  always_comb begin
    c_bus  = c_force ? c_force_val : alu_fn(alu_operation, a_bus, b_bus);
    z_flag = (c_bus == '0) ^ z_invert;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: update registers and push the expected completion
  task automatic model_cmd(input logic [3:0] op, input logic [1:0] src, input logic [W-1:0] imm);
    logic [W-1:0] b, c;
    if (op >= 4'd12 || (op == 4'd0 && src == 2'b11)) begin
      exp_q.push_back({1'b1, m_zero, m_ac});
    end else if (op == 4'd0) begin
      case (src)
        2'b00: m_r1 = m_ac;
        2'b01: m_r2 = m_ac;
        default: begin m_ac = imm; m_zero = (imm == '0); end
      endcase
      exp_q.push_back({1'b0, m_zero, m_ac});
    end else begin
      case (src)
        2'b00: b = m_r1;
        2'b01: b = m_r2;
        2'b10: b = imm;
        default: b = '0;
      endcase
      c = alu_fn(op, m_ac, b);
      m_zero = (op == 4'd2) ? ((c == '0) ^ z_invert) : (c == '0);
      m_ac = c;
      exp_q.push_back({1'b0, m_zero, m_ac});
    end
  endtask

  task automatic pop_check(input string tag);
    logic [W+1:0] e;
    chk({tag, "_q_nonempty"}, exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_ac"}, ac, e[W-1:0]);
      chk({tag, "_zero"}, zero, e[W]);
      chk({tag, "_err"}, err, e[W+1]);
    end
  endtask

  // drive one command and check latency, enable length, stability, result
  task automatic do_cmd(input string tag, input logic [3:0] op, input logic [1:0] src,
                        input logic [W-1:0] imm);
    int g, edges, en_cnt, stray;
    int exp_lat, exp_en;
    logic stable;
    logic [W-1:0] a0, b0;
    logic [3:0] op0;
    logic is_alu;
    is_alu  = (op != 4'd0) && (op < 4'd12);
    exp_lat = is_alu ? L + 3 : 1;
    exp_en  = is_alu ? L + 1 : 0;
    model_cmd(op, src, imm);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_imm = imm;
    g = 0;
    while (!cmd_ready && g < 20) begin @(negedge clk); g++; end
    chk({tag, "_ready_timeout"}, g < 20, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op  = 4'($urandom_range(0, 15));
    cmd_src = 2'($urandom_range(0, 3));
    cmd_imm = W'($urandom);
    en_cnt = alu_enable ? 1 : 0;
    a0 = a_bus; b0 = b_bus; op0 = alu_operation;
    stable = 1'b1; edges = 0; stray = 0;
    while (!done && edges < 40) begin
      @(posedge clk);
      edges++;
      #1;
      if (alu_enable) begin
        en_cnt++;
        if (a_bus !== a0 || b_bus !== b0 || alu_operation !== op0) stable = 1'b0;
      end
      if (err && !done) stray++;
    end
    chk({tag, "_latency"}, edges, exp_lat);
    chk({tag, "_enable_cycles"}, en_cnt, exp_en);
    chk({tag, "_bus_stable"}, stable, 1);
    chk({tag, "_err_without_done"}, stray, 0);
    pop_check(tag);
    @(posedge clk);
    #1;
    chk({tag, "_done_one_cycle"}, {done, err}, 2'b00);
  endtask

  initial begin
    int g, acc, dn, rises, extra;
    logic prev_en, will_acc;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_src = '0; cmd_imm = '0;

    // reset behaviour
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready_low", cmd_ready, 0);
    chk("rst_ac", ac, 0);
    chk("rst_flags", {zero, done, err, alu_enable}, 4'b0000);
    chk("rst_alu_operation", alu_operation, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", cmd_ready, 1);

    // move imm, then ADD with immediate
    do_cmd("mov_imm5", 4'd0, 2'b10, 24'h000005);
    do_cmd("add_imm3", 4'd1, 2'b10, 24'h000003);
    chk("add_result_8", ac, 24'h000008);

    // move to R1, SUB R1 -> zero from z_flag
    do_cmd("mov_r1", 4'd0, 2'b00, 24'h0);
    chk("r1_on_b_bus", b_bus, m_r1);
    do_cmd("sub_r1", 4'd2, 2'b00, 24'h0);
    chk("sub_zero_set", {ac, zero}, {24'h000000, 1'b1});

    // SUB takes zero from z_flag; other ops use c_bus==0
    do_cmd("mov_imm9", 4'd0, 2'b10, 24'h000009);
    z_invert = 1'b1;
    do_cmd("sub_zflag", 4'd2, 2'b10, 24'h000004);
    do_cmd("add_ignore_zflag", 4'd1, 2'b10, 24'h000006);
    z_invert = 1'b0;

    // illegal commands leave registers alone; R1 still holds 8
    do_cmd("illegal_1101", 4'd13, 2'b01, 24'h123456);
    do_cmd("illegal_mov_src3", 4'd0, 2'b11, 24'h654321);
    do_cmd("sub_r1_after_illegal", 4'd2, 2'b00, 24'h0);

    // R2 and zero source
    do_cmd("mov_imm7", 4'd0, 2'b10, 24'h000007);
    do_cmd("mov_r2", 4'd0, 2'b01, 24'h0);
    do_cmd("add_r2", 4'd1, 2'b01, 24'h0);
    do_cmd("add_zero_src", 4'd1, 2'b11, 24'hABCDEF);
    do_cmd("mov_imm0", 4'd0, 2'b10, 24'h000000);

    // reset while waiting on the ALU
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd1; cmd_src = 2'b10; cmd_imm = 24'h000002;
    g = 0;
    while (!cmd_ready && g < 20) begin @(negedge clk); g++; end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    g = 0;
    while (fsm_state != 3'd2 && g < 10) begin @(posedge clk); #1; g++; end
    chk("reach_wait", fsm_state, 3'd2);
    @(negedge clk);
    c_force = 1'b1; c_force_val = 24'hFFFFFF;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midop_rst_ac", ac, 0);
    chk("midop_rst_flags", {done, alu_enable, cmd_ready}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midop_ready_after_rst", cmd_ready, 1);
    extra = 0;
    repeat (10) begin @(posedge clk); #1; if (done) extra++; end
    chk("midop_no_done", extra, 0);
    chk("midop_ac_still_0", ac, 0);
    c_force = 1'b0;
    m_ac = '0; m_r1 = '0; m_r2 = '0; m_zero = 1'b0;

    // three ADDs with cmd_valid held high
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd1; cmd_src = 2'b10; cmd_imm = 24'h000001;
    acc = 0; dn = 0; rises = 0; prev_en = alu_enable;
    for (int cyc = 0; cyc < 80 && dn < 3; cyc++) begin
      will_acc = cmd_valid && cmd_ready;
      if (will_acc) model_cmd(4'd1, 2'b10, 24'h000001);
      @(posedge clk);
      #1;
      if (will_acc) begin
        acc++;
        if (acc == 3) cmd_valid = 1'b0;
      end
      if (done) begin pop_check("b2b"); dn++; end
      if (alu_enable && !prev_en) rises++;
      prev_en = alu_enable;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    extra = 0;
    repeat (12) begin @(posedge clk); #1; if (done) extra++; end
    chk("b2b_acceptances", acc, 3);
    chk("b2b_done_pulses", dn + extra, 3);
    chk("b2b_enable_rises", rises, 3);
    chk("b2b_final_ac", ac, 24'h000003);

    // overflow of increment
    do_cmd("mov_ffffff", 4'd0, 2'b10, 24'hFFFFFF);
    do_cmd("incac_wrap", 4'd3, 2'b00, 24'h0);
    chk("incac_wrap_result", {ac, zero}, {24'h000000, 1'b1});

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
